// File: rtl/ipg_chunk_sched.sv
// ipg_chunk_sched: per-channel IPG chunk queues drained one chunk per TX slot
// into the PHY TX path, round-robin or strict-priority arbitrated.
module ipg_chunk_sched #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_CH       = 4,
    parameter int DEPTH        = 16,
    parameter int PAUSE_THRESH = 12,
    parameter int ARB_MODE     = 0,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_write,
    output logic [NUM_CH-1:0]            in_pause,
    output logic [NUM_CH-1:0]            in_overflow,
    input  logic                         ovf_clear,
    input  logic                         tx_slot,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CW-1:0]                out_ch,
    output logic [NUM_CH*(AW+1)-1:0]     level
);

    logic [DATA_WIDTH-1:0] ram [NUM_CH][DEPTH];

    logic [NUM_CH-1:0][AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [NUM_CH-1:0][AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NUM_CH-1:0][AW:0]   level_q, level_d;
    logic [NUM_CH-1:0]         pause_q, pause_d;
    logic [NUM_CH-1:0]         ovf_q, ovf_d;
    logic [CW-1:0]             last_q, last_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
    logic [CW-1:0]             out_ch_q, out_ch_d;

    logic [NUM_CH-1:0] nonempty, wr_ok, pop;
    logic [CW-1:0]     gnt, rr_idx;
    logic              any;

    always_comb begin
        nonempty = '0;
        wr_ok    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            nonempty[i] = level_q[i] != '0;
            // Acceptance uses the pre-pop level: a full queue drops even if popped.
            wr_ok[i] = in_write[i] && (level_q[i] < (AW+1)'(DEPTH));
        end
        any = |nonempty;
    end

    always_comb begin
        gnt    = '0;
        rr_idx = '0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_CH - 1; i >= 0; i--)
                if (nonempty[i]) gnt = CW'(i);
        end else begin
            // Walk backwards so the nearest channel after last_q wins.
            for (int k = NUM_CH; k >= 1; k--) begin
                rr_idx = CW'((int'(last_q) + k) % NUM_CH);
                if (nonempty[rr_idx]) gnt = rr_idx;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++)
            pop[i] = tx_slot && any && (gnt == CW'(i));
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        pause_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_ok[i]) wr_ptr_d[i] = wr_ptr_q[i] + AW'(1);
            if (pop[i])   rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
            if (wr_ok[i] && !pop[i])
                level_d[i] = level_q[i] + (AW+1)'(1);
            else if (!wr_ok[i] && pop[i])
                level_d[i] = level_q[i] - (AW+1)'(1);
            pause_d[i] = level_d[i] >= (AW+1)'(PAUSE_THRESH);
        end
        ovf_d       = (ovf_clear ? '0 : ovf_q) | (in_write & ~wr_ok);
        out_valid_d = tx_slot && any;
        last_d      = out_valid_d ? gnt : last_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (out_valid_d) begin
            out_data_d = ram[gnt][rd_ptr_q[gnt]];
            out_ch_d   = gnt;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            if (wr_ok[i])
                ram[i][wr_ptr_q[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pause_q     <= '0;
            ovf_q       <= '0;
            last_q      <= CW'(NUM_CH - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            pause_q     <= pause_d;
            ovf_q       <= ovf_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign in_pause    = pause_q;
    assign in_overflow = ovf_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_ch      = out_ch_q;
    assign level       = level_q;

endmodule

// File: tb/tb_ipg_chunk_sched.sv
// tb_ipg_chunk_sched: directed checks of ipg_chunk_sched, one round-robin
// instance and one strict-priority instance.
`timescale 1ns/1ps
module tb_ipg_chunk_sched;
    localparam int DW = 64;
    localparam int NC = 4;
    localparam int LW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC*DW-1:0] in_data, sp_data;
    logic [NC-1:0]    in_write, in_pause, in_overflow;
    logic [NC-1:0]    sp_write, sp_pause, sp_ovf;
    logic             ovf_clear, tx_slot, sp_clear, sp_slot;
    logic             out_valid, sp_valid;
    logic [DW-1:0]    out_data, sp_out;
    logic [1:0]       out_ch, sp_ch;
    logic [NC*LW-1:0] level, sp_level;

    int n_chk = 0;
    int n_err = 0;

    ipg_chunk_sched #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(16),
                      .PAUSE_THRESH(12), .ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_write(in_write),
        .in_pause(in_pause), .in_overflow(in_overflow),
        .ovf_clear(ovf_clear), .tx_slot(tx_slot), .out_valid(out_valid),
        .out_data(out_data), .out_ch(out_ch), .level(level)
    );

    ipg_chunk_sched #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(16),
                      .PAUSE_THRESH(12), .ARB_MODE(1)) dut_sp (
        .clk(clk), .rst_n(rst_n), .in_data(sp_data), .in_write(sp_write),
        .in_pause(sp_pause), .in_overflow(sp_ovf),
        .ovf_clear(sp_clear), .tx_slot(sp_slot), .out_valid(sp_valid),
        .out_data(sp_out), .out_ch(sp_ch), .level(sp_level)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] lv(input int ch);
        return level[ch*LW +: LW];
    endfunction

    initial begin
        in_data = '0; in_write = '0; ovf_clear = 1'b0; tx_slot = 1'b0;
        sp_data = '0; sp_write = '0; sp_clear = 1'b0; sp_slot = 1'b0;

        // reset and idle
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_pause", 64'(in_pause), 64'd0);
        check("rst_ovf", 64'(in_overflow), 64'd0);
        rst_n = 1'b1;
        tx_slot = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_valid", 64'(out_valid), 64'd0);
        end
        check("idle_level", 64'(level), 64'd0);
        check("idle_pause", 64'(in_pause), 64'd0);
        tx_slot = 1'b0;

        // strict priority: ch0 drains fully before ch2
        sp_write = 4'b0101;
        for (int j = 0; j < 2; j++) begin
            sp_data[0*DW +: DW] = 64'h10 + 64'(j);
            sp_data[2*DW +: DW] = 64'h20 + 64'(j);
            tick();
        end
        sp_write = '0;
        sp_slot = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("sp_valid", 64'(sp_valid), 64'd1);
            check("sp_ch", 64'(sp_ch), (c < 2) ? 64'd0 : 64'd2);
            check("sp_data", sp_out,
                  (c < 2) ? 64'h10 + 64'(c) : 64'h20 + 64'(c - 2));
        end
        tick();
        check("sp_empty", 64'(sp_valid), 64'd0);
        sp_slot = 1'b0;

        // strict priority: ch2 only while ch0 empty
        sp_write = 4'b0100;
        for (int j = 0; j < 4; j++) begin
            sp_data[2*DW +: DW] = 64'h200 + 64'(j);
            tick();
        end
        sp_slot = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sp_write = (c % 2 == 0) ? 4'b0001 : 4'b0000;
            sp_data[0*DW +: DW] = 64'h100 + 64'(c);
            tick();
            check("sp2_ch", 64'(sp_ch), (c % 2 == 0) ? 64'd2 : 64'd0);
            check("sp2_data", sp_out, (c % 2 == 0) ?
                  64'h200 + 64'(c / 2) : 64'h100 + 64'(c - 1));
        end
        sp_write = '0;
        tick();
        check("sp2_empty", 64'(sp_valid), 64'd0);
        sp_slot = 1'b0;

        // round-robin fairness
        in_write = 4'hF;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NC; i++)
                in_data[i*DW +: DW] = 64'hC000 | 64'(r << 4) | 64'(i);
            tick();
        end
        in_write = '0;
        check("rr_level", 64'(level), 64'h18C63);
        tx_slot = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("rr_valid", 64'(out_valid), 64'd1);
            check("rr_ch", 64'(out_ch), 64'(k % 4));
            check("rr_data", out_data,
                  64'hC000 | 64'((k / 4) << 4) | 64'(k % 4));
        end
        tick();
        check("rr_done", 64'(out_valid), 64'd0);
        tx_slot = 1'b0;

        // fill channel 1: pause, full, overflow
        in_write = 4'b0010;
        for (int w = 1; w <= 17; w++) begin
            in_data[1*DW +: DW] = 64'(w);
            tick();
            check("fill_level", 64'(lv(1)), (w > 16) ? 64'd16 : 64'(w));
            check("fill_pause", 64'(in_pause[1]), (w >= 12) ? 64'd1 : 64'd0);
            check("fill_ovf", 64'(in_overflow), (w == 17) ? 64'd2 : 64'd0);
        end
        in_write = '0;
        ovf_clear = 1'b1;
        tick();
        check("ovf_clear", 64'(in_overflow), 64'd0);
        ovf_clear = 1'b0;

        // write and pop on a full queue: write dropped
        in_write = 4'b0010;
        in_data[1*DW +: DW] = 64'h99;
        tx_slot = 1'b1;
        tick();
        check("fullpop_ch", 64'(out_ch), 64'd1);
        check("fullpop_data", out_data, 64'd1);
        check("fullpop_level", 64'(lv(1)), 64'd15);
        check("fullpop_ovf", 64'(in_overflow), 64'd2);
        in_write = '0;
        ovf_clear = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            ovf_clear = 1'b0;
            check("drain_data", out_data, 64'(k + 2));
        end
        tick();
        check("drain_empty", 64'(out_valid), 64'd0);
        check("drain_level", 64'(level), 64'd0);
        check("drain_ovf", 64'(in_overflow), 64'd0);
        tx_slot = 1'b0;

        // channel 0 at level 5: write and pop together
        in_write = 4'b0001;
        for (int j = 0; j < 5; j++) begin
            in_data[0*DW +: DW] = 64'h500 + 64'(j);
            tick();
        end
        check("l5_level", 64'(lv(0)), 64'd5);
        in_data[0*DW +: DW] = 64'h505;
        tx_slot = 1'b1;
        tick();
        check("l5_ch", 64'(out_ch), 64'd0);
        check("l5_data", out_data, 64'h500);
        check("l5_keep", 64'(lv(0)), 64'd5);
        in_write = '0;
        tick();
        check("mid_valid", 64'(out_valid), 64'd1);

        // asynchronous reset while busy
        rst_n = 1'b0;
        tx_slot = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_data", out_data, 64'd0);
        check("arst_ch", 64'(out_ch), 64'd0);
        check("arst_level", 64'(level), 64'd0);
        check("arst_pause", 64'(in_pause), 64'd0);
        tick();
        rst_n = 1'b1;
        in_write = 4'b1001;
        in_data[0*DW +: DW] = 64'hA0;
        in_data[3*DW +: DW] = 64'hA3;
        tick();
        in_write = '0;
        tx_slot = 1'b1;
        tick();
        check("post_ch0", 64'(out_ch), 64'd0);
        check("post_d0", out_data, 64'hA0);
        tick();
        check("post_ch3", 64'(out_ch), 64'd3);
        check("post_d3", out_data, 64'hA3);
        tick();
        check("post_empty", 64'(out_valid), 64'd0);
        tx_slot = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
